// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate sweep checker family: reference-mode
// encodings and the sweep FSM state type.
package gate_sweep_pkg;

  // Reference gate function selector
  localparam logic [1:0] MODE_AND  = 2'b00;
  localparam logic [1:0] MODE_OR   = 2'b01;
  localparam logic [1:0] MODE_XOR  = 2'b10;
  localparam logic [1:0] MODE_NAND = 2'b11;

  // Sweep controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/gate_ref.sv
// Combinational reference model of an N-input gate. The mode input selects
// AND, OR, XOR or NAND reduction of vec.
module gate_ref
  import gate_sweep_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [1:0]   mode,
  input  logic [N-1:0] vec,
  output logic         f
);

  // Select the reduction that matches the requested gate
  always_comb begin
    f = 1'b0;
    case (mode)
      MODE_AND:  f = &vec;
      MODE_OR:   f = |vec;
      MODE_XOR:  f = ^vec;
      MODE_NAND: f = ~&vec;
      default:   f = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive stimulus engine for N-input combinational gates. Walks vec
// through every combination in ascending order, holds each value for HOLD
// cycles, samples the DUT at the end of the hold and accumulates a
// saturating error count plus the first failing vector.
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int N     = 2,
  parameter int HOLD  = 3,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  output logic [N-1:0]     vec,
  input  logic             f_dut,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [N-1:0]     first_err_vec
);

  // A single-cycle hold still needs a one-bit counter that never advances
  localparam int CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);
  localparam logic [N-1:0]     VEC_LAST = {N{1'b1}};
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       vec_q, vec_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               pass_q, pass_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic               fev_valid_q, fev_valid_d;
  logic [N-1:0]       fev_q, fev_d;

  logic               f_ref_s;
  logic               mismatch_s;

  gate_ref #(.N(N)) u_gate_ref (
    .mode (mode_q),
    .vec  (vec_q),
    .f    (f_ref_s)
  );

  // The DUT disagrees with the latched reference for the current vector
  always_comb begin
    mismatch_s = (f_dut != f_ref_s);
  end

  // Next-state and next-output logic for the sweep controller
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    vec_d       = vec_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_d       = err_q;
    fev_valid_d = fev_valid_q;
    fev_d       = fev_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d      = mode;
          cnt_d       = '0;
          vec_d       = '0;
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          err_d       = '0;
          fev_valid_d = 1'b0;
          fev_d       = '0;
          state_d     = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        if (cnt_q == CNT_LAST) begin
          if (mismatch_s) begin
            if (err_q != ERR_MAX) begin
              err_d = err_q + ERR_W'(1);
            end else begin
              err_d = err_q;
            end
            if (!fev_valid_q) begin
              fev_valid_d = 1'b1;
              fev_d       = vec_q;
            end else begin
              fev_valid_d = fev_valid_q;
            end
          end else begin
            err_d = err_q;
          end

          if (vec_q == VEC_LAST) begin
            // The error counter may have saturated, so pass is derived from
            // whether any mismatch was ever seen rather than from its value
            pass_d  = ~(fev_valid_q | mismatch_s);
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_FIN;
          end else begin
            vec_d = vec_q + N'(1);
            cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Controller state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_AND;
      cnt_q       <= '0;
      vec_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      fev_valid_q <= 1'b0;
      fev_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      vec_q       <= vec_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      fev_valid_q <= fev_valid_d;
      fev_q       <= fev_d;
    end
  end

  assign vec             = vec_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_q;
  assign first_err_valid = fev_valid_q;
  assign first_err_vec   = fev_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker using three instances:
//   u0: N=2, HOLD=3, ERR_W=8 driving an AND gate
//   u1: N=3, HOLD=1, ERR_W=8 with the DUT output stuck at 0
//   u2: N=3, HOLD=3, ERR_W=2 driving an AND gate (inverted NAND)
module tb_gate_sweep_checker;

  logic clk = 1'b0;
  logic rst_n;

  logic       start0, start1, start2;
  logic [1:0] mode0, mode1, mode2;

  logic [1:0] vec0;
  logic [2:0] vec1, vec2;
  logic       f0, f1, f2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;
  logic       pass0, pass1, pass2;
  logic [7:0] err0, err1;
  logic [1:0] err2;
  logic       vld0, vld1, vld2;
  logic [1:0] fev0;
  logic [2:0] fev1, fev2;

  int vectors     = 0;
  int miscompares = 0;
  int done_seen;

  always #5 clk = ~clk;

  assign f0 = &vec0;
  assign f1 = 1'b0;
  assign f2 = &vec2;

  gate_sweep_checker #(.N(2), .HOLD(3), .ERR_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .mode(mode0), .vec(vec0),
    .f_dut(f0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .first_err_valid(vld0), .first_err_vec(fev0)
  );

  gate_sweep_checker #(.N(3), .HOLD(1), .ERR_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .vec(vec1),
    .f_dut(f1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .first_err_valid(vld1), .first_err_vec(fev1)
  );

  gate_sweep_checker #(.N(3), .HOLD(3), .ERR_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .vec(vec2),
    .f_dut(f2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .first_err_valid(vld2), .first_err_vec(fev2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full u0 sweep: start pulse, per-cycle vec/busy/done, then the result
  task automatic sweep0(input logic [1:0] m, input logic [7:0] e_err,
                        input logic [1:0] e_fev, input logic e_vld, input logic e_pass);
    @(negedge clk);
    mode0  = m;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("u0 err cleared at start", err0, 0);
    chk("u0 vld cleared at start", vld0, 0);
    for (int c = 0; c < 12; c++) begin
      chk("u0 vec", vec0, c / 3);
      chk("u0 busy", busy0, 1);
      chk("u0 done low", done0, 0);
      @(negedge clk);
    end
    chk("u0 done", done0, 1);
    chk("u0 busy in done", busy0, 0);
    chk("u0 vec held", vec0, 3);
    chk("u0 err", err0, e_err);
    chk("u0 fev", fev0, e_fev);
    chk("u0 vld", vld0, e_vld);
    chk("u0 pass", pass0, e_pass);
    @(negedge clk);
    chk("u0 done one cycle", done0, 0);
    chk("u0 pass stable", pass0, e_pass);
    chk("u0 err stable", err0, e_err);
  endtask

  initial begin
    rst_n  = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    mode0  = 2'b00; mode1 = 2'b10; mode2 = 2'b11;
    #1;
    chk("rst vec", vec0, 0);
    chk("rst busy", busy0, 0);
    chk("rst done", done0, 0);
    chk("rst pass", pass0, 0);
    chk("rst err", err0, 0);
    chk("rst vld", vld0, 0);
    chk("rst fev", fev0, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // AND reference, correct AND DUT: clean sweep
    sweep0(2'b00, 8'd0, 2'd0, 1'b0, 1'b1);
    // OR reference, AND DUT: misses at 01 and 10
    sweep0(2'b01, 8'd2, 2'd1, 1'b1, 1'b0);

    // XOR reference, DUT stuck at 0, HOLD=1: misses at 1,2,4,7
    @(negedge clk);
    mode1  = 2'b10;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("u1 vec", vec1, c);
      chk("u1 done low", done1, 0);
      @(negedge clk);
    end
    chk("u1 done", done1, 1);
    chk("u1 err", err1, 4);
    chk("u1 fev", fev1, 1);
    chk("u1 vld", vld1, 1);
    chk("u1 pass", pass1, 0);

    // NAND reference, inverted DUT, 2-bit counter: saturates at 3
    @(negedge clk);
    mode2  = 2'b11;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int c = 0; c < 24; c++) begin
      chk("u2 vec", vec2, c / 3);
      @(negedge clk);
    end
    chk("u2 done", done2, 1);
    chk("u2 err saturated", err2, 3);
    chk("u2 fev", fev2, 0);
    chk("u2 vld", vld2, 1);
    chk("u2 pass", pass2, 0);

    // Reset mid-sweep while vec=2
    @(negedge clk);
    mode0  = 2'b00;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (6) @(negedge clk);
    chk("u0 vec before reset", vec0, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst vec", vec0, 0);
    chk("mid rst busy", busy0, 0);
    chk("mid rst done", done0, 0);
    chk("mid rst u1 err", err1, 0);
    chk("mid rst u1 fev", fev1, 0);
    chk("mid rst u2 vld", vld2, 0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done0) done_seen++;
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (done0) done_seen++;
    end
    chk("no done after reset", done_seen, 0);
    sweep0(2'b00, 8'd0, 2'd0, 1'b0, 1'b1);

    // start pulse and mode change during RUN are ignored
    @(negedge clk);
    mode0  = 2'b00;
    start0 = 1'b1;
    @(negedge clk);
    start0    = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 16; c++) begin
      if (c < 12) chk("u0 vec ignore", vec0, c / 3);
      if (c == 12) chk("u0 done ignore", done0, 1);
      if (done0) done_seen++;
      if (c == 4) begin
        start0 = 1'b1;
        mode0  = 2'b01;
      end
      if (c == 5) start0 = 1'b0;
      @(negedge clk);
    end
    chk("single done", done_seen, 1);
    chk("ignore err", err0, 0);
    chk("ignore pass", pass0, 1);
    chk("ignore busy idle", busy0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
